// File: rtl/uart_frame_arbiter.sv
// Packet-granular round-robin arbiter sharing one uart_tx byte channel between two requesters.
// Each packet goes out as: HEADER, source ID, payload, XOR checksum (source ID ^ payload).
module uart_frame_arbiter #(
    parameter logic [7:0] HEADER     = 8'hAD,
    parameter logic [7:0] SRC_ID0    = 8'h01,
    parameter logic [7:0] SRC_ID1    = 8'h02,
    parameter int         MAX_LEN    = 32,
    parameter int         GAP_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  req0_data,
    input  logic        req0_valid,
    input  logic        req0_last,
    output logic        req0_ready,
    input  logic [7:0]  req1_data,
    input  logic        req1_valid,
    input  logic        req1_last,
    output logic        req1_ready,
    output logic [7:0]  tx_data,
    output logic        tx_data_valid,
    input  logic        tx_data_ready,
    output logic        grant,
    output logic        busy,
    output logic        trunc_pulse,
    output logic [15:0] frame_cnt
);

    typedef enum logic [2:0] {IDLE, HDR, SRC, DATA, CSUM, GAP} state_t;

    state_t      state_q, state_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_valid_q, tx_valid_d;
    logic        grant_q, grant_d;
    logic        last_grant_q, last_grant_d;
    logic [7:0]  csum_q, csum_d;
    logic [7:0]  count_q, count_d;
    logic [15:0] gap_q, gap_d;
    logic        trunc_q, trunc_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        csum_loaded_q, csum_loaded_d;

    logic        g_valid, g_last, g_ready, g_hs, out_xfer;
    logic [7:0]  g_data, src_id;

    assign g_valid  = grant_q ? req1_valid : req0_valid;
    assign g_last   = grant_q ? req1_last  : req0_last;
    assign g_data   = grant_q ? req1_data  : req0_data;
    assign src_id   = grant_q ? SRC_ID1    : SRC_ID0;
    assign out_xfer = tx_valid_q && tx_data_ready;
    // The payload slot is free when it is empty or is being drained this very edge.
    assign g_ready  = (state_q == DATA) && (!tx_valid_q || tx_data_ready);
    assign g_hs     = g_ready && g_valid;

    assign req0_ready    = g_ready && !grant_q;
    assign req1_ready    = g_ready && grant_q;
    assign tx_data       = tx_data_q;
    assign tx_data_valid = tx_valid_q;
    assign grant         = grant_q;
    assign busy          = (state_q != IDLE);
    assign trunc_pulse   = trunc_q;
    assign frame_cnt     = frame_cnt_q;

    always_comb begin
        // NOTE: every always_comb target gets a default first so no path can infer a latch.
        state_d       = state_q;
        tx_data_d     = tx_data_q;
        tx_valid_d    = tx_valid_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        csum_d        = csum_q;
        count_d       = count_q;
        gap_d         = gap_q;
        trunc_d       = 1'b0;
        frame_cnt_d   = frame_cnt_q;
        csum_loaded_d = csum_loaded_q;

        unique case (state_q)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    grant_d      = (req0_valid && req1_valid) ? !last_grant_q : req1_valid;
                    last_grant_d = grant_d;
                    tx_data_d    = HEADER;
                    tx_valid_d   = 1'b1;
                    state_d      = HDR;
                end
            end
            HDR: begin
                if (out_xfer) begin
                    tx_data_d = src_id;
                    csum_d    = src_id;
                    count_d   = 8'd0;
                    state_d   = SRC;
                end
            end
            SRC: begin
                if (out_xfer) begin
                    tx_valid_d = 1'b0;
                    state_d    = DATA;
                end
            end
            DATA: begin
                if (g_hs) begin
                    tx_data_d  = g_data;
                    tx_valid_d = 1'b1;
                    csum_d     = csum_q ^ g_data;
                    count_d    = 8'(count_q + 8'd1);
                    if (g_last || count_q == 8'(MAX_LEN - 1)) begin
                        trunc_d = !g_last;
                        state_d = CSUM;
                    end
                end else if (out_xfer) begin
                    tx_valid_d = 1'b0;
                end
            end
            CSUM: begin
                // csum_loaded_q tells the still-pending last payload byte apart from the checksum.
                if (!csum_loaded_q) begin
                    if (!tx_valid_q || tx_data_ready) begin
                        tx_data_d     = csum_q;
                        tx_valid_d    = 1'b1;
                        csum_loaded_d = 1'b1;
                    end
                end else if (tx_data_ready) begin
                    tx_valid_d    = 1'b0;
                    csum_loaded_d = 1'b0;
                    frame_cnt_d   = 16'(frame_cnt_q + 16'd1);
                    gap_d         = 16'd0;
                    state_d       = (GAP_CYCLES == 0) ? IDLE : GAP;
                end
            end
            GAP: begin
                if (gap_q == 16'(GAP_CYCLES - 1)) state_d = IDLE;
                else                              gap_d   = 16'(gap_q + 16'd1);
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            tx_data_q     <= 8'd0;
            tx_valid_q    <= 1'b0;
            grant_q       <= 1'b0;
            last_grant_q  <= 1'b1;
            csum_q        <= 8'd0;
            count_q       <= 8'd0;
            gap_q         <= 16'd0;
            trunc_q       <= 1'b0;
            frame_cnt_q   <= 16'd0;
            csum_loaded_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            tx_data_q     <= tx_data_d;
            tx_valid_q    <= tx_valid_d;
            grant_q       <= grant_d;
            last_grant_q  <= last_grant_d;
            csum_q        <= csum_d;
            count_q       <= count_d;
            gap_q         <= gap_d;
            trunc_q       <= trunc_d;
            frame_cnt_q   <= frame_cnt_d;
            csum_loaded_q <= csum_loaded_d;
        end
    end

endmodule

// File: tb/tb_uart_frame_arbiter.sv
// Directed bench for uart_frame_arbiter: dut_a uses default parameters, dut_b uses MAX_LEN=4, GAP_CYCLES=0.
module tb_uart_frame_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Requester index: 0 = dut_a req0, 1 = dut_a req1, 2 = dut_b req0, 3 = dut_b req1
    logic [7:0] rd [4];
    logic       rv [4];
    logic       rl [4];
    logic [7:0] pk [4][8];
    logic       rdy0_a, rdy1_a, rdy0_b, rdy1_b;

    logic [7:0]  txd_a, txd_b;
    logic        txv_a, txv_b;
    logic        txr_a = 1'b1, txr_b = 1'b1;
    logic        grant_a, grant_b, busy_a, busy_b, trunc_a, trunc_b;
    logic [15:0] fcnt_a, fcnt_b;

    uart_frame_arbiter dut_a (
        .clk(clk), .rst_n(rst_n),
        .req0_data(rd[0]), .req0_valid(rv[0]), .req0_last(rl[0]), .req0_ready(rdy0_a),
        .req1_data(rd[1]), .req1_valid(rv[1]), .req1_last(rl[1]), .req1_ready(rdy1_a),
        .tx_data(txd_a), .tx_data_valid(txv_a), .tx_data_ready(txr_a),
        .grant(grant_a), .busy(busy_a), .trunc_pulse(trunc_a), .frame_cnt(fcnt_a)
    );

    uart_frame_arbiter #(.MAX_LEN(4), .GAP_CYCLES(0)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .req0_data(rd[2]), .req0_valid(rv[2]), .req0_last(rl[2]), .req0_ready(rdy0_b),
        .req1_data(rd[3]), .req1_valid(rv[3]), .req1_last(rl[3]), .req1_ready(rdy1_b),
        .tx_data(txd_b), .tx_data_valid(txv_b), .tx_data_ready(txr_b),
        .grant(grant_b), .busy(busy_b), .trunc_pulse(trunc_b), .frame_cnt(fcnt_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Transfer monitors, sampled on the falling edge between active edges
    logic [7:0] txq_a[$], txq_b[$], expq[$];
    logic       gq_a[$];
    int         trunc_cnt_b = 0;
    int         stall_cnt   = 0;
    logic       prev_stall  = 1'b0;
    logic [7:0] prev_d      = 8'd0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_hold_valid", txv_a, 1'b1);
                check("stall_hold_data", txd_a, prev_d);
            end
            if (txv_a && !txr_a) begin
                stall_cnt++;
                check("stall_req0_ready", rdy0_a, 1'b0);
            end
            prev_stall = txv_a && !txr_a;
            prev_d     = txd_a;
            if (txv_a && txr_a) begin
                txq_a.push_back(txd_a);
                gq_a.push_back(grant_a);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (txv_b && txr_b) txq_b.push_back(txd_b);
            if (trunc_b) trunc_cnt_b++;
        end
    end

    function automatic logic get_ready(input int idx);
        case (idx)
            0:       return rdy0_a;
            1:       return rdy1_a;
            2:       return rdy0_b;
            default: return rdy1_b;
        endcase
    endfunction

    function automatic logic [15:0] get_fcnt(input int inst);
        return (inst == 0) ? fcnt_a : fcnt_b;
    endfunction

    task automatic drive(input int idx, input int n);
        for (int i = 0; i < n; i++) begin
            int t = 0;
            rd[idx] = pk[idx][i];
            rl[idx] = (i == n - 1);
            rv[idx] = 1'b1;
            do begin
                @(negedge clk);
                t++;
            end while (!get_ready(idx) && t < 3000);
            if (t >= 3000) check($sformatf("drv%0d_timeout", idx), get_ready(idx), 1'b1);
            @(posedge clk);
            #1;
        end
        rv[idx] = 1'b0;
        rl[idx] = 1'b0;
    endtask

    task automatic wait_fcnt(input int inst, input logic [15:0] target, input string tag);
        int t = 0;
        while (get_fcnt(inst) !== target && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check(tag, get_fcnt(inst), target);
    endtask

    task automatic wait_idle_a();
        int t = 0;
        while (busy_a && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check("wait_idle_a", busy_a, 1'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic cmp_frames(input string tag, input bit on_b);
        logic [7:0] got[$];
        if (on_b) got = txq_b;
        else      got = txq_a;
        check({tag, "_len"}, got.size(), expq.size());
        for (int i = 0; i < expq.size() && i < got.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), got[i], expq[i]);
    endtask

    task automatic clear_q();
        txq_a.delete();
        gq_a.delete();
        txq_b.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_q();
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cnt;
        for (int k = 0; k < 4; k++) begin
            rd[k] = 8'd0;
            rv[k] = 1'b0;
            rl[k] = 1'b0;
        end

        // Reset values
        do_reset();
        @(negedge clk);
        check("rst_tx_data", txd_a, 8'h00);
        check("rst_tx_valid", txv_a, 1'b0);
        check("rst_req0_ready", rdy0_a, 1'b0);
        check("rst_req1_ready", rdy1_a, 1'b0);
        check("rst_grant", grant_a, 1'b0);
        check("rst_busy", busy_a, 1'b0);
        check("rst_trunc", trunc_a, 1'b0);
        check("rst_frame_cnt", fcnt_a, 16'h0000);
        @(posedge clk);
        #1;

        // Single two-byte frame from req0, then 16-cycle gap
        pk[0][0] = 8'h12;
        pk[0][1] = 8'h34;
        drive(0, 2);
        wait_fcnt(0, 16'd1, "t1_frame_cnt");
        cnt = 0;
        while (busy_a && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        check("t1_gap_busy_cycles", cnt, 16);
        expq = {8'hAD, 8'h01, 8'h12, 8'h34, 8'h27};
        cmp_frames("t1", 1'b0);

        // Simultaneous requests after reset: req0 first, then req1, then alternation repeats
        do_reset();
        pk[0][0] = 8'h55;
        pk[1][0] = 8'hFF;
        fork
            drive(0, 1);
            drive(1, 1);
        join
        wait_fcnt(0, 16'd2, "t2_frame_cnt");
        expq = {8'hAD, 8'h01, 8'h55, 8'h54, 8'hAD, 8'h02, 8'hFF, 8'hFD};
        cmp_frames("t2", 1'b0);
        if (gq_a.size() == 8) begin
            check("t2_grant_first", gq_a[0], 1'b0);
            check("t2_grant_second", gq_a[4], 1'b1);
        end
        wait_idle_a();
        clear_q();
        pk[0][0] = 8'h66;
        pk[1][0] = 8'h77;
        fork
            drive(0, 1);
            drive(1, 1);
        join
        wait_fcnt(0, 16'd4, "t2b_frame_cnt");
        expq = {8'hAD, 8'h01, 8'h66, 8'h67, 8'hAD, 8'h02, 8'h77, 8'h75};
        cmp_frames("t2b", 1'b0);
        if (gq_a.size() == 8) begin
            check("t2b_grant_first", gq_a[0], 1'b0);
            check("t2b_grant_second", gq_a[4], 1'b1);
        end

        // Output backpressure: tx_data_ready high one cycle in four
        wait_idle_a();
        clear_q();
        stall_cnt = 0;
        pk[0][0] = 8'hA1;
        pk[0][1] = 8'hB2;
        pk[0][2] = 8'hC3;
        pk[0][3] = 8'hD4;
        pk[0][4] = 8'hE5;
        begin
            bit stall_done = 1'b0;
            fork
                begin
                    int cyc = 0;
                    txr_a = 1'b0;
                    while (!stall_done) begin
                        @(posedge clk);
                        #1;
                        cyc++;
                        txr_a = (cyc % 4 == 0);
                    end
                    txr_a = 1'b1;
                end
                begin
                    drive(0, 5);
                    wait_fcnt(0, 16'd5, "t3_frame_cnt");
                    stall_done = 1'b1;
                end
            join
        end
        expq = {8'hAD, 8'h01, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hE0};
        cmp_frames("t3", 1'b0);
        check("t3_stalls_seen", (stall_cnt > 0), 1'b1);

        // Asynchronous reset in the middle of a req0 payload
        wait_idle_a();
        pk[0][0] = 8'h11;
        pk[0][1] = 8'h22;
        pk[0][2] = 8'h33;
        rd[0] = 8'h11;
        rl[0] = 1'b0;
        rv[0] = 1'b1;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!rdy0_a && cnt < 200);
        check("t5_reach_data", rdy0_a, 1'b1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_tx_data", txd_a, 8'h00);
        check("t5_rst_tx_valid", txv_a, 1'b0);
        check("t5_rst_req0_ready", rdy0_a, 1'b0);
        check("t5_rst_grant", grant_a, 1'b0);
        check("t5_rst_busy", busy_a, 1'b0);
        check("t5_rst_trunc", trunc_a, 1'b0);
        check("t5_rst_frame_cnt", fcnt_a, 16'h0000);
        rv[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        clear_q();
        drive(0, 3);
        wait_fcnt(0, 16'd1, "t5_frame_cnt");
        expq = {8'hAD, 8'h01, 8'h11, 8'h22, 8'h33, 8'h01};
        cmp_frames("t5", 1'b0);

        // MAX_LEN=4 truncation on dut_b: six bytes split into two frames
        trunc_cnt_b = 0;
        for (int i = 0; i < 6; i++) pk[3][i] = 8'(i + 1);
        drive(3, 6);
        wait_fcnt(1, 16'd2, "t4_frame_cnt");
        expq = {8'hAD, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h06,
                8'hAD, 8'h02, 8'h05, 8'h06, 8'h01};
        cmp_frames("t4", 1'b1);
        check("t4_trunc_pulses", trunc_cnt_b, 1);

        // frame_cnt wrap on dut_b, counter preset near the top
        @(posedge clk);
        #1;
        force dut_b.frame_cnt_q = 16'hFFFE;
        @(posedge clk);
        #1;
        release dut_b.frame_cnt_q;
        @(negedge clk);
        check("t6_preset", fcnt_b, 16'hFFFE);
        @(posedge clk);
        #1;
        pk[2][0] = 8'h10;
        drive(2, 1);
        wait_fcnt(1, 16'hFFFF, "t6_frame_cnt_ffff");
        clear_q();
        @(posedge clk);
        #1;
        drive(2, 1);
        wait_fcnt(1, 16'h0000, "t6_frame_cnt_wrap");
        expq = {8'hAD, 8'h01, 8'h10, 8'h11};
        cmp_frames("t6", 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_frame_arbiter.md
Name: uart_frame_arbiter

Overview:
- Shares the single uart_tx byte channel (tx_data / tx_data_valid / tx_data_ready) between two packet requesters, e.g. the demod status reporter and the echo/command responder.
- Arbitration is packet-granular round-robin.
- Each packet is wrapped as a frame: header 0xAD, source ID byte, payload, XOR checksum byte.
- Sits between the requester logic and the uart_tx instance, replacing the ad-hoc tx_cnt sequencing.

Parameters:
- HEADER, 8'hAD, frame header byte
- SRC_ID0, 8'h01, source ID byte emitted for requester 0
- SRC_ID1, 8'h02, source ID byte emitted for requester 1
- MAX_LEN, 32, maximum payload bytes per frame (1..255)
- GAP_CYCLES, 16, idle clk cycles forced between frames (0 allowed)

Ports:
- clk  in  1  system clock (50 MHz)
- rst_n  in  1  asynchronous reset, active low
- req0_data  in  8  requester 0 payload byte
- req0_valid  in  1  requester 0 byte valid
- req0_last  in  1  requester 0 last payload byte of packet
- req0_ready  out  1  requester 0 byte accepted when valid&&ready
- req1_data / req1_valid / req1_last / req1_ready  as requester 0
- tx_data  out  8  byte to uart_tx
- tx_data_valid  out  1  byte valid to uart_tx
- tx_data_ready  in  1  uart_tx ready
- grant  out  1  index of requester owning the current frame
- busy  out  1  high in any state other than IDLE
- trunc_pulse  out  1  one-cycle pulse when a frame is closed at MAX_LEN without last
- frame_cnt  out  16  count of completed frames; wraps 0xFFFF->0

Behaviour:
- Reset (async, rst_n low) forces: tx_data=0, tx_data_valid=0, req0_ready=req1_ready=0, grant=0, busy=0, trunc_pulse=0, frame_cnt=0, state=IDLE, last_grant=1, checksum=0, payload count=0.
- Reset mid-frame abandons the frame. No partial checksum is emitted.
- Output channel is a registered stage:
  - tx_data/tx_data_valid are held stable while valid && !ready.
  - A transfer occurs on valid && ready at a clk edge.
- States: IDLE, HDR, SRC, DATA, CSUM, GAP.
- IDLE:
  - If any reqN_valid, pick a winner. One requester valid: that one. Both valid: the one != last_grant.
  - Latch grant and last_grant, load tx_data=HEADER, tx_data_valid=1, state<=HDR.
  - Header therefore appears 1 cycle after the request is seen.
  - req*_ready=0 in IDLE.
- HDR: on transfer, load tx_data=SRC_IDgrant, checksum<=SRC_IDgrant, count<=0, state<=SRC.
- SRC: on transfer, tx_data_valid<=0, state<=DATA.
- DATA:
  - reqG_ready = (!tx_data_valid || tx_data_ready); the non-granted ready is 0.
  - On a requester handshake: tx_data<=byte, tx_data_valid<=1, checksum^=byte, count+=1.
  - If no handshake and the output transfers, tx_data_valid<=0.
  - On accepting a byte with last=1, or the MAX_LEN-th byte: reqG_ready drops next cycle and state<=CSUM.
  - trunc_pulse fires in the same cycle if closed by MAX_LEN with last=0.
  - Remaining bytes of a truncated packet form a new arbitrated frame.
- CSUM:
  - While the last payload byte is still pending, hold it.
  - Once it transfers, load tx_data=checksum (including the last byte), tx_data_valid=1.
  - On checksum transfer: tx_data_valid<=0, frame_cnt+=1, state<=GAP, or IDLE if GAP_CYCLES==0.
- GAP: count GAP_CYCLES clk cycles, then IDLE. Requests arriving here wait.
- Checksum = SRC_ID XOR all payload bytes. The header byte is excluded.
- Requesters must hold valid/data until ready. A requester dropping valid mid-packet simply stalls DATA; there is no timeout.
- tx_data_ready high while tx_data_valid=0 has no effect.

Test Plan:
- req0 sends {0x12,0x34(last)}, tx_data_ready=1, GAP_CYCLES=16 -> tx bytes AD,01,12,34,27. frame_cnt=1, busy low 16 cycles after the checksum transfer.
- Both requesters valid in the same cycle after reset, req1 packet {0xFF(last)} -> req0 frame first (grant=0), then AD,02,FF,FD with grant=1. A second simultaneous request grants req0 again (alternation).
- tx_data_ready toggled 1-of-4 cycles during a 5-byte payload -> tx_data stable whenever valid&&!ready; byte order and checksum unchanged; req0_ready never high while output is stalled-full.
- MAX_LEN=4, req1 streams 6 bytes 01..06 with last on 06 -> frame AD,02,01,02,03,04,06 with trunc_pulse once; then second frame AD,02,05,06,01.
- rst_n pulsed low during the DATA state of req0 -> all outputs at reset values immediately (asynchronously). After release, req0 resends and the full frame is correct with frame_cnt counting from 0.
- frame_cnt preset by sending 65536 one-byte frames (GAP_CYCLES=0, accelerated bench) -> frame_cnt wraps to 0.
